mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port `Memory` block (DEPTH×WIDTH, one read/write port, registered read data) between the instruction-fetch (IF) port and the load/store (LS) port. Each port has a valid/ready request handshake and a one-cycle-latency response. At most one memory access is issued per cycle. The block sits between the core's fetch/LSU stages and `Memory`.

## Interface
- `DEPTH`, 256, memory words; power of two
- `WIDTH`, 32, data word width
- `AW`, `$clog2(DEPTH)`, address width (derived; do not override)

- `clk_i` in 1 clock; all logic on rising edge
- `rst_i` in 1 synchronous, active-high reset
- `if_req_valid_i` in 1 IF read request
- `if_req_ready_o` out 1 IF request accepted this cycle
- `if_addr_i` in AW IF word address
- `if_rsp_valid_o` out 1 IF read data valid
- `if_rsp_data_o` out WIDTH IF read data
- `ls_req_valid_i` in 1 LS request
- `ls_req_ready_o` out 1 LS request accepted this cycle
- `ls_we_i` in 1 1 = write, 0 = read
- `ls_addr_i` in AW LS word address
- `ls_wdata_i` in WIDTH LS write data
- `ls_rsp_valid_o` out 1 LS read data valid / write ack
- `ls_rsp_data_o` out WIDTH LS read data; 0 on write ack
- `mem_rw_en_o` out 1 to `Memory` rw_en (1 = write)
- `mem_addr_o` out AW to `Memory` addr
- `mem_data_o` out WIDTH to `Memory` write data
- `mem_data_i` in WIDTH from `Memory` data_o (valid one cycle after address)

## Operation
- Request transfers when `*_req_valid_i && *_req_ready_o` in the same cycle (a "grant"). Requesters hold address/data stable while valid and not ready.
- Grant logic is combinational from the valids and the `last_grant` register. Exactly one grant when either port requests; none when neither does.
- Only one valid: that port is granted.
- Both valid: see Configuration. `last_grant` updates to the granted port on each grant and holds otherwise.
- Granted port drives the memory outputs in the grant cycle: `mem_addr_o` = its address; `mem_rw_en_o` = `ls_we_i` for LS, 0 for IF; `mem_data_o` = `ls_wdata_i` for LS, 0 otherwise.
- No grant: `mem_rw_en_o`=0, `mem_addr_o`=0, `mem_data_o`=0.
- Response register state: `rsp_pend` (1 bit), `rsp_port` (IF/LS), `rsp_is_wr` (1 bit), all captured on grant.
- Cycle after grant: the owning port's `*_rsp_valid_o`=1 for exactly one cycle. Read data = `mem_data_i`. Write ack has data = 0.
- Responses cannot be back-pressured; requesters must accept them.
- A new grant may occur in the same cycle as a response (full throughput, one access per cycle).
- Reads after writes to the same address in back-to-back grants return the new data. `Memory` write-then-read ordering provides this.

## Timing
- Reset (sync, `rst_i`=1 at edge): `rsp_pend`=0, `last_grant`=IF. All `*_rsp_valid_o`=0, `*_rsp_data_o`=0. Ready outputs follow the valids combinationally even during reset; grants during reset are discarded (no memory write: `mem_rw_en_o` forced 0 while `rst_i`=1).
- Reset asserted the cycle after a grant: the pending response is dropped; no `rsp_valid` is issued.
- Latency: request-to-response = 1 cycle. Sustained throughput = 1 access/cycle total across both ports.
- `*_rsp_data_o` holds its last value when `*_rsp_valid_o`=0 (reset value 0).

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. On conflict, grant the port not in `last_grant`. From reset, the first conflict goes to LS, then alternates.
- `MEM_ARB_RR_EN` undefined: fixed priority. LS always wins conflicts. `last_grant` is still maintained but unused for the decision. IF may starve under continuous LS traffic; this is accepted.

## Test plan
- Reset: hold `rst_i`=1 for 3 cycles with both valids high and `ls_we_i`=1 -> `mem_rw_en_o`=0 throughout, no `rsp_valid`, memory contents unchanged.
- LS write 0xDEADBEEF to addr 0x10, then IF read addr 0x10 next cycle -> `ls_rsp_valid_o` pulse with data 0, then `if_rsp_valid_o` pulse with 0xDEADBEEF.
- Both ports read continuously, with IF addr 0x01 (mem=0x11) and LS addr 0x02 (mem=0x22), with `MEM_ARB_RR_EN` -> grants alternate LS, IF, LS, …, and responses alternate 0x22/0x11 one cycle later.
- Same as the previous scenario without `MEM_ARB_RR_EN` -> `ls_req_ready_o`=1 every cycle, `if_req_ready_o`=0 every cycle, only LS responses.
- Sweep: LS writes random values to addrs 0..255 back-to-back, then IF reads 0..255 back-to-back -> 256 IF responses on consecutive cycles, each matching the written value.
- LS read granted, `rst_i` asserted the next cycle -> `ls_rsp_valid_o` stays 0, and the first post-reset conflict is granted to LS (RR build).

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port Memory between the IF and LS request ports.
// Ports: clk_i/rst_i (sync, active-high). IF read port: if_req_valid_i/if_req_ready_o/if_addr_i
// with response if_rsp_valid_o/if_rsp_data_o. LS port: ls_req_valid_i/ls_req_ready_o/ls_we_i/
// ls_addr_i/ls_wdata_i with response ls_rsp_valid_o/ls_rsp_data_o. Memory side: mem_rw_en_o,
// mem_addr_o and mem_data_o out, mem_data_i in (registered read data, one cycle after the address).
// Build option: define MEM_ARB_RR_EN for round-robin on conflicts; otherwise LS has fixed priority.
module mem_arbiter #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             if_req_valid_i,
  output logic             if_req_ready_o,
  input  logic [AW-1:0]    if_addr_i,
  output logic             if_rsp_valid_o,
  output logic [WIDTH-1:0] if_rsp_data_o,
  input  logic             ls_req_valid_i,
  output logic             ls_req_ready_o,
  input  logic             ls_we_i,
  input  logic [AW-1:0]    ls_addr_i,
  input  logic [WIDTH-1:0] ls_wdata_i,
  output logic             ls_rsp_valid_o,
  output logic [WIDTH-1:0] ls_rsp_data_o,
  output logic             mem_rw_en_o,
  output logic [AW-1:0]    mem_addr_o,
  output logic [WIDTH-1:0] mem_data_o,
  input  logic [WIDTH-1:0] mem_data_i
);
  logic last_grant;
  logic ls_wins, gnt_ls, gnt_if;
  logic rsp_pend, rsp_port, rsp_is_wr;
  logic [WIDTH-1:0] rsp_val, if_hold, ls_hold;
`ifdef MEM_ARB_RR_EN
  assign ls_wins = !last_grant;
`else
  // last_grant is tracked for observability but never changes the fixed priority
  assign ls_wins = 1'b1 | last_grant;
`endif
  always_comb begin
    gnt_ls         = ls_req_valid_i & (!if_req_valid_i | ls_wins);
    gnt_if         = if_req_valid_i & !gnt_ls;
    ls_req_ready_o = gnt_ls;
    if_req_ready_o = gnt_if;
    mem_rw_en_o    = gnt_ls & ls_we_i & !rst_i;
    mem_addr_o     = gnt_ls ? ls_addr_i : gnt_if ? if_addr_i : '0;
    mem_data_o     = gnt_ls ? ls_wdata_i : '0;
    rsp_val        = rsp_is_wr ? '0 : mem_data_i;
    // a response pending across a reset edge is dropped
    if_rsp_valid_o = rsp_pend & !rsp_port & !rst_i;
    ls_rsp_valid_o = rsp_pend & rsp_port & !rst_i;
    if_rsp_data_o  = if_rsp_valid_o ? rsp_val : if_hold;
    ls_rsp_data_o  = ls_rsp_valid_o ? rsp_val : ls_hold;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_pend   <= 1'b0;
      rsp_port   <= 1'b0;
      rsp_is_wr  <= 1'b0;
      last_grant <= 1'b0;
      if_hold    <= '0;
      ls_hold    <= '0;
    end else begin
      rsp_pend <= gnt_ls | gnt_if;
      if (gnt_ls | gnt_if) begin
        rsp_port   <= gnt_ls;
        rsp_is_wr  <= gnt_ls & ls_we_i;
        last_grant <= gnt_ls;
      end
      if (if_rsp_valid_o) if_hold <= if_rsp_data_o;
      if (ls_rsp_valid_o) ls_hold <= ls_rsp_data_o;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural single-port Memory.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic if_v = 1'b0, ls_v = 1'b0, ls_we = 1'b0;
  logic [7:0] if_a = '0, ls_a = '0;
  logic [31:0] ls_wd = '0;
  logic if_rdy, ls_rdy, if_rv, ls_rv, m_we;
  logic [31:0] if_rd, ls_rd, m_wd;
  logic [31:0] m_rd = '0;
  logic [7:0] m_a;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  typedef struct { bit port; logic [31:0] data; } rsp_t;
  rsp_t sb[$];
  int n_cmp = 0, n_err = 0, if_cnt = 0;
  bit lg = 1'b0;
  logic [31:0] last_if = '0, last_ls = '0;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_valid_i(if_v), .if_req_ready_o(if_rdy), .if_addr_i(if_a),
    .if_rsp_valid_o(if_rv), .if_rsp_data_o(if_rd),
    .ls_req_valid_i(ls_v), .ls_req_ready_o(ls_rdy), .ls_we_i(ls_we),
    .ls_addr_i(ls_a), .ls_wdata_i(ls_wd),
    .ls_rsp_valid_o(ls_rv), .ls_rsp_data_o(ls_rd),
    .mem_rw_en_o(m_we), .mem_addr_o(m_a), .mem_data_o(m_wd), .mem_data_i(m_rd)
  );
  always @(posedge clk) begin
    if (m_we) mem[m_a] <= m_wd;
    m_rd <= mem[m_a];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    rsp_t e;
    bit has, g_ls, g_if, wins;
    if (rst) begin
      check("rst_if_v", {31'b0, if_rv}, 32'd0);
      check("rst_ls_v", {31'b0, ls_rv}, 32'd0);
      check("rst_we", {31'b0, m_we}, 32'd0);
      sb.delete();
      lg = 1'b0;
      last_if = '0;
      last_ls = '0;
    end else begin
      has = sb.size() > 0;
      if (has) e = sb.pop_front();
      check("if_v", {31'b0, if_rv}, {31'b0, has && !e.port});
      check("ls_v", {31'b0, ls_rv}, {31'b0, has && e.port});
      if (has && !e.port) begin
        check("if_data", if_rd, e.data);
        last_if = e.data;
        if_cnt++;
      end else check("if_hold", if_rd, last_if);
      if (has && e.port) begin
        check("ls_data", ls_rd, e.data);
        last_ls = e.data;
      end else check("ls_hold", ls_rd, last_ls);
`ifdef MEM_ARB_RR_EN
      wins = !lg;
`else
      wins = 1'b1;
`endif
      g_ls = ls_v && (!if_v || wins);
      g_if = if_v && !g_ls;
      check("ls_rdy", {31'b0, ls_rdy}, {31'b0, g_ls});
      check("if_rdy", {31'b0, if_rdy}, {31'b0, g_if});
      check("mem_we", {31'b0, m_we}, {31'b0, g_ls && ls_we});
      check("mem_addr", {24'b0, m_a}, {24'b0, g_ls ? ls_a : g_if ? if_a : 8'h00});
      if (g_ls) begin
        sb.push_back('{1'b1, ls_we ? 32'h0 : ref_mem[ls_a]});
        if (ls_we) ref_mem[ls_a] = ls_wd;
        lg = 1'b1;
      end else if (g_if) begin
        sb.push_back('{1'b0, ref_mem[if_a]});
        lg = 1'b0;
      end
    end
  end
  task automatic drive(input bit r, input bit iv, input logic [7:0] ia, input bit lv,
                       input bit we, input logic [7:0] la, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; if_v = iv; if_a = ia; ls_v = lv; ls_we = we; ls_a = la; ls_wd = wd;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[1] = 32'h11; ref_mem[1] = 32'h11;
    mem[2] = 32'h22; ref_mem[2] = 32'h22;
    rst = 1'b1; if_v = 1'b1; ls_v = 1'b1; ls_we = 1'b1; ls_a = 8'h10; ls_wd = 32'hBAD0BAD0;
    repeat (2) drive(1, 1, 8'h10, 1, 1, 8'h10, 32'hBAD0BAD0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("rst_mem", mem[8'h10], 32'h0);
    drive(0, 0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    drive(0, 1, 8'h10, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    repeat (8) drive(0, 1, 8'h01, 1, 0, 8'h02, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) drive(0, 0, 0, 1, 1, 8'(i), $urandom);
    if_cnt = 0;
    for (int i = 0; i < 256; i++) drive(0, 1, 8'(i), 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0);
    check("sweep_cnt", 32'(if_cnt), 32'd256);
    drive(0, 0, 0, 1, 0, 8'h05, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 8'h03, 1, 0, 8'h04, 0);
    drive(0, 1, 8'h03, 0, 0, 0, 0);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
